// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM-stage controller and its load/store alignment unit.
package mem_stage_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Unshifted byte-strobe pattern for the access size encoded in funct3[1:0].
  function automatic logic [7:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [2:0] off);
    case (funct3[1:0])
      2'b01:   return off[0];
      2'b10:   return |off[1:0];
      2'b11:   return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Port bundle of mem_stage_ctrl: EX/MEM entry, data-memory bus and MEM/WB output.
// out_misalign is present only when MEM_STAGE_MISALIGN_CHECK_EN is defined.
interface mem_stage_ctrl_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
);

  logic              in_valid;
  logic              in_ready;
  logic              in_mem_r_en;
  logic              in_mem_w_en;
  logic [2:0]        in_funct3;
  logic [XLEN-1:0]   in_exu_result;
  logic [XLEN-1:0]   in_x_rs2;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wen;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN/8-1:0] req_wmask;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_lsu_r_data;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  logic              out_misalign;
`endif

  modport master (
    input  in_valid, in_mem_r_en, in_mem_w_en, in_funct3, in_exu_result, in_x_rs2,
    input  req_ready, resp_valid, resp_rdata, out_ready,
    output in_ready, req_valid, req_addr, req_wen, req_wdata, req_wmask,
    output out_valid, out_lsu_r_data
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    , output out_misalign
`endif
  );

  modport slave (
    output in_valid, in_mem_r_en, in_mem_w_en, in_funct3, in_exu_result, in_x_rs2,
    output req_ready, resp_valid, resp_rdata, out_ready,
    input  in_ready, req_valid, req_addr, req_wen, req_wdata, req_wmask,
    input  out_valid, out_lsu_r_data
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    , input out_misalign
`endif
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store data/strobe placement and load shift with sign/zero extension.
module lsu_align #(
  parameter int XLEN = 64
) (
  input  logic [2:0]        off,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN/8-1:0] wmask,
  output logic [XLEN-1:0]   load_data
);
  import mem_stage_pkg::*;

  localparam int NB = XLEN / 8;

  logic [5:0]      bit_off;
  logic [XLEN-1:0] shifted;

  assign bit_off = {off, 3'b000};
  assign wdata   = store_data << bit_off;
  assign wmask   = NB'(size_mask(funct3)) << off;
  assign shifted = rdata >> bit_off;

  // Extension works on the already right-justified doubleword.
  always_comb begin
    load_data = shifted;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_BU:   load_data = {{(XLEN-8){1'b0}},         shifted[7:0]};
      F3_HU:   load_data = {{(XLEN-16){1'b0}},        shifted[15:0]};
      F3_WU:   load_data = {{(XLEN-32){1'b0}},        shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: one data-memory transaction per load/store, zero-latency pass-through otherwise.
// Optional misalignment trap enabled by MEM_STAGE_MISALIGN_CHECK_EN.
module mem_stage_ctrl #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst,
  mem_stage_ctrl_if.master bus
);
  import mem_stage_pkg::*;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        off_q;
  logic [2:0]        funct3_q;
  logic              wen_q;
  logic [XLEN-1:0]   lsu_r_data_q;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] wmask;
  logic              is_mem;
  logic              misalign_now;
  logic              in_ready;
  logic              out_valid;
  logic              req_valid;
  logic              unused_upper;

  assign is_mem       = bus.in_mem_r_en | bus.in_mem_w_en;
  assign unused_upper = ^bus.in_exu_result[XLEN-1:ADDR_W];

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  logic misalign_q;

  assign misalign_now     = misaligned(bus.in_funct3, bus.in_exu_result[2:0]);
  assign bus.out_misalign = (state == DONE) && misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (state == IDLE && bus.in_valid && is_mem) begin
      misalign_q <= misalign_now;
    end
  end
`else
  assign misalign_now = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Access attributes are captured at acceptance; upper address and store data stay valid
  // because the EX/MEM entry is held until in_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q        <= 3'b000;
      funct3_q     <= 3'b000;
      wen_q        <= 1'b0;
      lsu_r_data_q <= '0;
    end else begin
      if (state == IDLE && bus.in_valid && is_mem) begin
        off_q    <= bus.in_exu_result[2:0];
        funct3_q <= bus.in_funct3;
        wen_q    <= bus.in_mem_w_en;
      end
      if (state == WAIT && bus.resp_valid && !wen_q) begin
        lsu_r_data_q <= load_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    req_valid = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (!is_mem) begin
            out_valid = 1'b1;
            in_ready  = bus.out_ready;
          end else begin
            state_nxt = misalign_now ? DONE : REQ;
          end
        end
      end
      REQ: begin
        req_valid = 1'b1;
        if (bus.req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.resp_valid) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .off        (off_q),
    .funct3     (funct3_q),
    .store_data (bus.in_x_rs2),
    .rdata      (bus.resp_rdata),
    .wdata      (wdata),
    .wmask      (wmask),
    .load_data  (load_data)
  );

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid;
  assign bus.req_valid      = req_valid;
  assign bus.req_addr       = {bus.in_exu_result[ADDR_W-1:3], 3'b000};
  assign bus.req_wen        = wen_q;
  assign bus.req_wdata      = wdata;
  assign bus.req_wmask      = wmask;
  assign bus.out_lsu_r_data = lsu_r_data_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed vector table, reset/stall sequences and randomized traffic
// against a byte-level reference model. Adapts to MEM_STAGE_MISALIGN_CHECK_EN.
module tb_mem_stage_ctrl;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 32;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  mem_stage_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        r_en;
    logic        w_en;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] rs2;
    logic [63:0] rdata;
    int          req_dly;
    int          resp_dly;
    int          out_dly;
    logic [31:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wmask;
    logic [63:0] exp_data;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_data;
  vec_t        vecs[$];

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic int size_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010, 3'b110: return 4;
      default:        return 8;
    endcase
  endfunction

  // Pick the addressed bytes out of the doubleword (bytes beyond lane 7 read as zero), then extend.
  function automatic logic [63:0] model_load(input logic [2:0] f3, input int off, input logic [63:0] rdata);
    logic [63:0] r;
    int          n;
    logic        sign;
    r = '0;
    n = size_bytes(f3);
    for (int i = 0; i < n; i++)
      if (off + i < 8) r[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) begin
      sign = r[8*n-1];
      for (int i = n; i < 8; i++) r[8*i +: 8] = {8{sign}};
    end
    return r;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] rs2, input int off);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++)
      if (i >= off) w[8*i +: 8] = rs2[8*(i-off) +: 8];
    return w;
  endfunction

  function automatic logic [7:0] model_wmask(input logic [2:0] f3, input int off);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++)
      m[i] = (i >= off) && (i < off + size_bytes(f3));
    return m;
  endfunction

  function automatic vec_t mk(input logic r, input logic w, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] rs2, input logic [63:0] rdata, input int rq, input int rs,
                              input int od, input logic [31:0] ea, input logic [63:0] ewd,
                              input logic [7:0] em, input logic [63:0] ed);
    vec_t v;
    v.r_en = r; v.w_en = w; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
    v.req_dly = rq; v.resp_dly = rs; v.out_dly = od;
    v.exp_addr = ea; v.exp_wdata = ewd; v.exp_wmask = em; v.exp_data = ed;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.in_valid      = 1'b0;
    bus.in_mem_r_en   = 1'b0;
    bus.in_mem_w_en   = 1'b0;
    bus.in_funct3     = 3'b000;
    bus.in_exu_result = '0;
    bus.in_x_rs2      = '0;
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_rdata    = '0;
    bus.out_ready     = 1'b0;
  endtask

  task automatic check_mis(input string tag, input logic exp);
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    check_output({tag, " out_misalign"}, 64'(bus.out_misalign), 64'(exp));
`else
    if (exp) $display("[TB] unexpected misalign expectation in %s", tag);
`endif
  endtask

  // Runs one load/store from acceptance through the MEM/WB handshake, checking every cycle.
  task automatic apply_stimulus(input vec_t v, input logic exp_mis, input string tag);
    bus.in_valid      = 1'b1;
    bus.in_mem_r_en   = v.r_en;
    bus.in_mem_w_en   = v.w_en;
    bus.in_funct3     = v.f3;
    bus.in_exu_result = v.addr;
    bus.in_x_rs2      = v.rs2;
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'($urandom_range(0, 1));
    bus.resp_rdata    = rnd64();
    bus.out_ready     = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_output({tag, " accept in_ready"}, 64'(bus.in_ready), 64'd0);
    check_output({tag, " accept out_valid"}, 64'(bus.out_valid), 64'd0);
    check_output({tag, " accept req_valid"}, 64'(bus.req_valid), 64'd0);
    next_cycle();
    if (!exp_mis) begin
      for (int n = 0; n <= v.req_dly; n++) begin
        bus.req_ready  = (n == v.req_dly);
        bus.resp_valid = 1'($urandom_range(0, 1));
        bus.resp_rdata = rnd64();
        bus.out_ready  = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_output({tag, " req_valid"}, 64'(bus.req_valid), 64'd1);
        check_output({tag, " req_addr"}, 64'(bus.req_addr), 64'(v.exp_addr));
        check_output({tag, " req_wen"}, 64'(bus.req_wen), 64'(v.w_en));
        if (v.w_en) begin
          check_output({tag, " req_wdata"}, bus.req_wdata, v.exp_wdata);
          check_output({tag, " req_wmask"}, 64'(bus.req_wmask), 64'(v.exp_wmask));
        end
        check_output({tag, " req in_ready"}, 64'(bus.in_ready), 64'd0);
        check_output({tag, " req out_valid"}, 64'(bus.out_valid), 64'd0);
        next_cycle();
      end
      for (int n = 0; n <= v.resp_dly; n++) begin
        bus.req_ready  = 1'($urandom_range(0, 1));
        bus.resp_valid = (n == v.resp_dly);
        bus.resp_rdata = (n == v.resp_dly) ? v.rdata : rnd64();
        bus.out_ready  = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_output({tag, " wait req_valid"}, 64'(bus.req_valid), 64'd0);
        check_output({tag, " wait in_ready"}, 64'(bus.in_ready), 64'd0);
        check_output({tag, " wait out_valid"}, 64'(bus.out_valid), 64'd0);
        next_cycle();
      end
    end
    for (int n = 0; n <= v.out_dly; n++) begin
      bus.out_ready  = (n == v.out_dly);
      bus.req_ready  = 1'($urandom_range(0, 1));
      bus.resp_valid = 1'($urandom_range(0, 1));
      bus.resp_rdata = rnd64();
      @(negedge clk);
      check_output({tag, " done out_valid"}, 64'(bus.out_valid), 64'd1);
      check_output({tag, " done in_ready"}, 64'(bus.in_ready), 64'(n == v.out_dly));
      check_output({tag, " done req_valid"}, 64'(bus.req_valid), 64'd0);
      check_output({tag, " out_lsu_r_data"}, bus.out_lsu_r_data, v.exp_data);
      if (MIS_EN) check_mis(tag, exp_mis);
      next_cycle();
    end
    set_idle();
    @(negedge clk);
    check_output({tag, " idle out_valid"}, 64'(bus.out_valid), 64'd0);
    check_output({tag, " idle data"}, bus.out_lsu_r_data, v.exp_data);
    if (MIS_EN) check_mis({tag, " idle"}, 1'b0);
    next_cycle();
  endtask

  task automatic alu_op(input int stall, input string tag);
    bus.in_valid      = 1'b1;
    bus.in_mem_r_en   = 1'b0;
    bus.in_mem_w_en   = 1'b0;
    bus.in_funct3     = 3'($urandom_range(0, 7));
    bus.in_exu_result = rnd64();
    bus.in_x_rs2      = rnd64();
    for (int n = 0; n <= stall; n++) begin
      bus.out_ready  = (n == stall);
      bus.req_ready  = 1'($urandom_range(0, 1));
      bus.resp_valid = 1'($urandom_range(0, 1));
      bus.resp_rdata = rnd64();
      @(negedge clk);
      check_output({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
      check_output({tag, " in_ready"}, 64'(bus.in_ready), 64'(n == stall));
      check_output({tag, " req_valid"}, 64'(bus.req_valid), 64'd0);
      check_output({tag, " data"}, bus.out_lsu_r_data, model_data);
      next_cycle();
    end
    set_idle();
    @(negedge clk);
    check_output({tag, " idle out_valid"}, 64'(bus.out_valid), 64'd0);
    check_output({tag, " idle in_ready"}, 64'(bus.in_ready), 64'd0);
    next_cycle();
  endtask

  task automatic random_mem_op(input string tag);
    vec_t v;
    int   off;
    int   nb;
    logic mis;
    v.w_en   = ($urandom_range(0, 2) == 0);
    v.r_en   = !v.w_en;
    v.f3     = v.w_en ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
    nb       = size_bytes(v.f3);
    off      = $urandom_range(0, 7);
    if ($urandom_range(0, 1) == 1) off = (off / nb) * nb;
    v.addr      = rnd64();
    v.addr[2:0] = 3'(off);
    v.rs2       = rnd64();
    v.rdata     = rnd64();
    v.req_dly   = $urandom_range(0, 3);
    v.resp_dly  = $urandom_range(0, 3);
    v.out_dly   = $urandom_range(0, 2);
    v.exp_addr  = {v.addr[31:3], 3'b000};
    v.exp_wdata = model_wdata(v.rs2, off);
    v.exp_wmask = model_wmask(v.f3, off);
    mis         = MIS_EN && ((off % nb) != 0);
    v.exp_data  = (v.r_en && !mis) ? model_load(v.f3, off, v.rdata) : model_data;
    apply_stimulus(v, mis, tag);
    model_data = v.exp_data;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    model_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset req_valid", 64'(bus.req_valid), 64'd0);
    check_output("reset out_valid", 64'(bus.out_valid), 64'd0);
    check_output("reset in_ready", 64'(bus.in_ready), 64'd0);
    check_output("reset data", bus.out_lsu_r_data, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    alu_op(0, "alu0");
    alu_op(2, "alu_stall");

    vecs.push_back(mk(1, 0, 3'b000, 64'h80000003, 64'h0, 64'h00000000_80000000, 0, 0, 0,
                      32'h80000000, 64'h0, 8'h00, 64'hFFFFFFFF_FFFFFF80));
    vecs.push_back(mk(0, 1, 3'b001, 64'h80000006, 64'h1234, 64'h0, 3, 0, 0,
                      32'h80000000, 64'h1234_0000_0000_0000, 8'hC0, 64'hFFFFFFFF_FFFFFF80));
    vecs.push_back(mk(1, 0, 3'b110, 64'h80000004, 64'h0, 64'h89ABCDEF_01234567, 0, 1, 2,
                      32'h80000000, 64'h0, 8'h00, 64'h00000000_89ABCDEF));
    vecs.push_back(mk(1, 0, 3'b011, 64'h00001008, 64'h0, 64'h01234567_89ABCDEF, 1, 1, 0,
                      32'h00001008, 64'h0, 8'h00, 64'h01234567_89ABCDEF));
    vecs.push_back(mk(1, 0, 3'b101, 64'h12, 64'h0, 64'h00000000_F00D0000, 0, 0, 0,
                      32'h10, 64'h0, 8'h00, 64'h00000000_0000F00D));
    vecs.push_back(mk(1, 0, 3'b001, 64'h12, 64'h0, 64'h00000000_F00D0000, 2, 0, 1,
                      32'h10, 64'h0, 8'h00, 64'hFFFFFFFF_FFFFF00D));
    vecs.push_back(mk(1, 0, 3'b010, 64'h20, 64'h0, 64'h00000000_80000001, 0, 2, 0,
                      32'h20, 64'h0, 8'h00, 64'hFFFFFFFF_80000001));
    vecs.push_back(mk(0, 1, 3'b000, 64'h25, 64'hAB, 64'h0, 1, 0, 0,
                      32'h20, 64'h0000_AB00_0000_0000, 8'h20, 64'hFFFFFFFF_80000001));
    vecs.push_back(mk(0, 1, 3'b011, 64'h38, 64'hDEADBEEF_CAFEF00D, 64'h0, 0, 0, 1,
                      32'h38, 64'hDEADBEEF_CAFEF00D, 8'hFF, 64'hFFFFFFFF_80000001));
    vecs.push_back(mk(1, 0, 3'b100, 64'h7, 64'h0, 64'h80FF0000_00000000, 0, 0, 0,
                      32'h0, 64'h0, 8'h00, 64'h00000000_00000080));
`ifndef MEM_STAGE_MISALIGN_CHECK_EN
    vecs.push_back(mk(0, 1, 3'b010, 64'h06, 64'h11223344, 64'h0, 0, 0, 0,
                      32'h0, 64'h3344_0000_0000_0000, 8'hC0, 64'h00000000_00000080));
    vecs.push_back(mk(1, 0, 3'b011, 64'h03, 64'h0, 64'h11223344_55667788, 0, 0, 0,
                      32'h0, 64'h0, 8'h00, 64'h00000011_22334455));
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i], 1'b0, $sformatf("tbl%0d", i));
      model_data = vecs[i].exp_data;
    end

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    apply_stimulus(mk(1, 0, 3'b010, 64'h80000002, 64'h0, 64'hFFFFFFFF_FFFFFFFF, 0, 0, 0,
                      32'h80000000, 64'h0, 8'h00, model_data), 1'b1, "misalign_lw");
    apply_stimulus(mk(0, 1, 3'b011, 64'h80000001, 64'h55, 64'h0, 0, 0, 2,
                      32'h80000000, 64'h0, 8'h00, model_data), 1'b1, "misalign_sd");
`endif

    // Abandon a request mid-flight: the request must drop asynchronously and a late response be ignored.
    bus.in_valid      = 1'b1;
    bus.in_mem_r_en   = 1'b1;
    bus.in_funct3     = 3'b011;
    bus.in_exu_result = 64'h100;
    next_cycle();
    @(negedge clk);
    check_output("rst pre req_valid", 64'(bus.req_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_output("rst async req_valid", 64'(bus.req_valid), 64'd0);
    check_output("rst async data", bus.out_lsu_r_data, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    set_idle();
    bus.resp_valid = 1'b1;
    bus.resp_rdata = 64'hFFFFFFFF_FFFFFFFF;
    @(negedge clk);
    check_output("rst late out_valid", 64'(bus.out_valid), 64'd0);
    check_output("rst late req_valid", 64'(bus.req_valid), 64'd0);
    next_cycle();
    bus.resp_valid = 1'b0;
    @(negedge clk);
    check_output("rst after out_valid", 64'(bus.out_valid), 64'd0);
    check_output("rst after data", bus.out_lsu_r_data, 64'd0);
    next_cycle();
    model_data = '0;
    alu_op(0, "rst alu");

    for (int k = 0; k < 160; k++) begin
      if ($urandom_range(0, 4) == 0) alu_op($urandom_range(0, 2), $sformatf("rnd%0d alu", k));
      else random_mem_op($sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
MEM-stage controller that sits upstream of the MEM/WB pipeline register and produces that register's inputs.
- Takes one instruction at a time from the EX/MEM register and, for loads and stores, runs a single valid/ready transaction on the data-memory bus.
- Aligns and extends load data, then presents the instruction to MEM/WB with a valid/ready handshake.
- Non-memory instructions pass straight through with zero added latency.

Parameters:
XLEN, 64, data width of register values, exu_result and bus data.
ADDR_W, 32, bus address width; address = exu_result[ADDR_W-1:0].

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  EX/MEM entry valid; entry inputs held stable while in_ready=0
in_ready  out  1  entry consumed this cycle
in_mem_r_en  in  1  load
in_mem_w_en  in  1  store (never asserted together with in_mem_r_en)
in_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
in_exu_result  in  XLEN  effective address / ALU result
in_x_rs2  in  XLEN  store data
req_valid  out  1  bus request valid
req_ready  in  1  bus accepts request
req_addr  out  ADDR_W  doubleword-aligned address ({addr[ADDR_W-1:3],3'b0})
req_wen  out  1  1 = store
req_wdata  out  XLEN  store data shifted to byte lane
req_wmask  out  XLEN/8  byte strobes
resp_valid  in  1  read data / write ack
resp_rdata  in  XLEN  read data (whole doubleword)
out_valid  out  1  to MEM/WB in_valid
out_ready  in  1  MEM/WB can accept
out_lsu_r_data  out  XLEN  aligned, extended load result

Behaviour:
- State machine IDLE, REQ, WAIT, DONE. Reset (asynchronous) forces IDLE, out_lsu_r_data=0, req_valid=0.
- IDLE, non-memory op: out_valid=in_valid; in_ready=in_valid&out_ready. Combinational, 0 cycles.
- IDLE, memory op with in_valid: out_valid=0, in_ready=0. Latch addr offset, funct3 and req_wen. Next state REQ.
- REQ: req_valid=1; req_addr/wdata/wmask/wen held constant until req_ready. On req_valid&req_ready, next state WAIT.
- WAIT: sample resp_valid only here; any resp_valid seen in other states is ignored. On resp_valid:
  - load: register the aligned and extended data into out_lsu_r_data.
  - store: out_lsu_r_data unchanged.
  - Next state DONE.
- DONE: out_valid=1. When out_ready=1, in_ready=1 and next state IDLE. When out_ready=0, hold DONE with data stable.
- Minimum memory-op latency: 4 cycles from acceptance to MEM/WB handshake (req_ready=1 in REQ, resp_valid in the first WAIT cycle).
- Store alignment: off=addr[2:0]; req_wdata = in_x_rs2 << (8*off); req_wmask = size mask (B 0x01, H 0x03, W 0x0F, D 0xFF) << off, truncated to 8 bits.
- Load alignment: shift resp_rdata right by 8*off, then sign- or zero-extend per funct3.
- Reset mid-transaction: return to IDLE immediately and drop the request. The bus must tolerate an abandoned request.
- in_ready is never 1 in REQ or WAIT.

Optional Feature:
MEM_STAGE_MISALIGN_CHECK_EN
- Defined: adds output out_misalign (1 bit, reset 0). Misaligned means H with off[0]≠0, W with off[1:0]≠0, or D with off≠0.
  - A misaligned memory op goes IDLE→DONE directly, with no bus request and out_lsu_r_data unchanged.
  - out_misalign=1 while in DONE for that op; otherwise 0.
- Undefined: no out_misalign port. Misaligned accesses issue unchanged; the mask is truncated as above.

Decomposition:
- Package mem_stage_pkg: state enum (IDLE/REQ/WAIT/DONE), funct3 size constants, size-mask function.
- Sub-module lsu_align, purely combinational: store shift/mask generation and load shift/extend. Instantiated once.
- FSM and registers stay in mem_stage_ctrl.

Test Plan:
- ALU op in_valid=1, out_ready=1, no mem enables -> out_valid=1 and in_ready=1 in the same cycle; req_valid stays 0.
- LB addr 0x80000003, resp_rdata=0x00000000_80000000, req_ready=1, resp after 1 cycle -> req_addr=0x80000000; out_lsu_r_data=0xFFFFFFFF_FFFFFF80; out_valid in cycle 4.
- SH addr 0x80000006, x_rs2=0x1234 -> req_wdata=0x1234_0000_0000_0000, req_wmask=0xC0, req_wen=1; req_ready held low 3 cycles -> request fields stable throughout.
- LWU with out_ready=0 for 2 cycles in DONE -> out_valid held and data stable; in_ready pulses once when out_ready rises.
- rst asserted while in REQ -> req_valid=0 asynchronously; state IDLE; a late resp_valid is ignored; the next ALU op passes through.
- (MISALIGN_CHECK_EN) LW addr 0x80000002 -> no req_valid; out_misalign=1 and out_valid=1 in cycle 2.
